// File: rtl/life_icon_renderer_if.sv
// Pixel/ROM/palette bundle between the raster source and the life icon renderer.
interface life_icon_renderer_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned CNT_W  = 3
);
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic              blank;
   logic              frame_start;
   logic [CNT_W-1:0]  lives_in;
   logic [ADDR_W-1:0] rom_addr;
   logic [IDX_W-1:0]  rom_q;
   logic [IDX_W-1:0]  pal_index;
   logic [3:0]        pal_red;
   logic [3:0]        pal_green;
   logic [3:0]        pal_blue;
   logic [3:0]        red;
   logic [3:0]        green;
   logic [3:0]        blue;
   logic              pixel_on;

   // Raster source side: supplies position, count, ROM data and palette colour.
   modport master (
      output DrawX, DrawY, blank, frame_start, lives_in, rom_q,
             pal_red, pal_green, pal_blue,
      input  rom_addr, pal_index, red, green, blue, pixel_on
   );

   // Renderer side.
   modport slave (
      input  DrawX, DrawY, blank, frame_start, lives_in, rom_q,
             pal_red, pal_green, pal_blue,
      output rom_addr, pal_index, red, green, blue, pixel_on
   );
endinterface

// File: rtl/life_icon_renderer.sv
// Draws a row of scaled life icons; a lost life blinks for a number of frames
// before disappearing. Two-clock pipeline from DrawX/DrawY to RGB/pixel_on.
module life_icon_renderer #(
   parameter int unsigned ICON_W       = 10,
   parameter int unsigned ICON_H       = 10,
   parameter int unsigned SCALE_SHIFT  = 2,
   parameter int unsigned MAX_LIVES    = 5,
   parameter int unsigned SPACING      = 4,
   parameter int unsigned X0           = 16,
   parameter int unsigned Y0           = 16,
   parameter int unsigned IDX_W        = 3,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned BLINK_FRAMES = 48,
   parameter int unsigned BLINK_BIT    = 2,
   parameter int unsigned CNT_W        = 3
) (
   input logic                vga_clk,
   input logic                reset,
   life_icon_renderer_if.slave bus
);

   localparam int unsigned PW      = ICON_W << SCALE_SHIFT;
   localparam int unsigned PH      = ICON_H << SCALE_SHIFT;
   localparam int unsigned PITCH   = PW + SPACING;
   localparam int unsigned ROW_W   = MAX_LIVES * PITCH;
   localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned POS_W   = 10;

   // Latched per-frame state.
   logic [CNT_W-1:0]   lives_q;
   logic [CNT_W-1:0]   ghost_slot;
   logic [BLINK_W-1:0] blink_left;

   // Pipeline registers.
   logic hit_d;
   logic blank_d;

   // Combinational geometry.
   logic [POS_W-1:0]  rel_x;
   logic [POS_W-1:0]  rel_y;
   logic [POS_W-1:0]  slot;
   logic [POS_W-1:0]  off;
   logic [POS_W-1:0]  texel_x;
   logic [POS_W-1:0]  texel_y;
   logic [31:0]       addr_full;
   logic              in_row;
   logic              ghost_vis;
   logic              slot_vis;
   logic              hit_c;
   logic [CNT_W-1:0]  n_c;
   logic              on_c;

   // Slot/offset decode and ROM texel address for the current pixel.
   always_comb begin
      rel_x     = bus.DrawX - POS_W'(X0);
      rel_y     = bus.DrawY - POS_W'(Y0);
      in_row    = (bus.DrawY >= POS_W'(Y0)) && (bus.DrawY < POS_W'(Y0 + PH)) &&
                  (bus.DrawX >= POS_W'(X0)) && (bus.DrawX < POS_W'(X0 + ROW_W));
      slot      = POS_W'(32'(rel_x) / PITCH);
      off       = rel_x - POS_W'(32'(slot) * PITCH);
      texel_x   = off >> SCALE_SHIFT;
      texel_y   = rel_y >> SCALE_SHIFT;
      addr_full = 32'(texel_y) * ICON_W + 32'(texel_x);
      ghost_vis = (blink_left != '0) && blink_left[BLINK_BIT];
      slot_vis  = (slot < POS_W'(lives_q)) ||
                  ((slot == POS_W'(ghost_slot)) && ghost_vis);
      hit_c     = in_row && (off < POS_W'(PW)) && slot_vis;
   end

   assign bus.rom_addr  = in_row ? ADDR_W'(addr_full) : '0;
   assign bus.pal_index = bus.rom_q;

   // Requested count clamped to the number of slots.
   assign n_c = (bus.lives_in > CNT_W'(MAX_LIVES)) ? CNT_W'(MAX_LIVES) : bus.lives_in;

   // Index 0 is transparent.
   assign on_c = hit_d && blank_d && (bus.rom_q != '0);

   // Frame latch: count, ghost slot and blink countdown update only on frame_start.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         lives_q    <= '0;
         ghost_slot <= '0;
         blink_left <= '0;
      end else if (bus.frame_start) begin
         if (n_c < lives_q) begin
            ghost_slot <= n_c;
            blink_left <= BLINK_W'(BLINK_FRAMES);
         end else if (n_c > lives_q) begin
            blink_left <= '0;
         end else if (blink_left != '0) begin
            blink_left <= blink_left - BLINK_W'(1);
         end
         lives_q <= n_c;
      end
   end

   // Stage 1: align hit/blank with the synchronous ROM read.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hit_d   <= 1'b0;
         blank_d <= 1'b0;
      end else begin
         hit_d   <= hit_c;
         blank_d <= bus.blank;
      end
   end

   // Stage 2: registered colour and opacity flag.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         bus.pixel_on <= 1'b0;
         bus.red      <= 4'd0;
         bus.green    <= 4'd0;
         bus.blue     <= 4'd0;
      end else begin
         bus.pixel_on <= on_c;
         bus.red      <= on_c ? bus.pal_red   : 4'd0;
         bus.green    <= on_c ? bus.pal_green : 4'd0;
         bus.blue     <= on_c ? bus.pal_blue  : 4'd0;
      end
   end

endmodule

// File: tb/tb_life_icon_renderer.sv
// Randomized self-checking bench for life_icon_renderer with a behavioural model.
module tb_life_icon_renderer;

   logic vga_clk = 1'b0;
   logic reset   = 1'b1;

   always #5 vga_clk = ~vga_clk;

   life_icon_renderer_if bus ();

   life_icon_renderer dut (
      .vga_clk (vga_clk),
      .reset   (reset),
      .bus     (bus)
   );

   // Sprite ROM contents and palette used by both the environment and the model.
   logic [2:0] rom [0:255];

   function automatic logic [11:0] palette(input logic [2:0] idx);
      return {1'b1, idx, idx, 1'b0, 4'(4'd15 - {1'b0, idx})};
   endfunction

   // Synchronous ROM, one-clock read latency.
   always @(posedge vga_clk) bus.rom_q <= rom[bus.rom_addr];

   logic [11:0] pal_rgb;
   assign pal_rgb       = palette(bus.pal_index);
   assign bus.pal_red   = pal_rgb[11:8];
   assign bus.pal_green = pal_rgb[7:4];
   assign bus.pal_blue  = pal_rgb[3:0];

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model state.
   int lives_m = 0;
   int ghost_m = 0;
   int blink_m = 0;

   function automatic bit model_in_row(input int x, input int y);
      return (y >= 16) && (y < 16 + 40) && (x >= 16) && (x < 16 + 5 * 44);
   endfunction

   function automatic int model_addr(input int x, input int y);
      if (!model_in_row(x, y)) return 0;
      return ((y - 16) / 4) * 10 + ((x - 16) % 44) / 4;
   endfunction

   // Expected {pixel_on, red, green, blue} for a pixel with the current model state.
   function automatic logic [12:0] model_pix(input int x, input int y, input bit bl);
      int  slot, off;
      bit  vis;
      logic [2:0] idx;
      if (reset || !bl || !model_in_row(x, y)) return 13'd0;
      slot = (x - 16) / 44;
      off  = (x - 16) % 44;
      vis  = (slot < lives_m) || (slot == ghost_m && blink_m != 0 && ((blink_m >> 2) & 1) == 1);
      if (off >= 40 || !vis) return 13'd0;
      idx = rom[model_addr(x, y)];
      if (idx == 3'd0) return 13'd0;
      return {1'b1, palette(idx)};
   endfunction

   task automatic model_frame(input int lv);
      int n;
      n = (lv > 5) ? 5 : lv;
      if (n < lives_m) begin
         ghost_m = n;
         blink_m = 48;
      end else if (n > lives_m) begin
         blink_m = 0;
      end else if (blink_m != 0) begin
         blink_m--;
      end
      lives_m = n;
   endtask

   logic [12:0] e0 = 13'd0;
   logic [12:0] e1 = 13'd0;

   // One pixel clock: check the output due from two steps ago, then drive new inputs.
   task automatic step(input int x, input int y, input bit bl, input bit fs, input int lv);
      @(negedge vga_clk);
      check("pix", 32'({bus.pixel_on, bus.red, bus.green, bus.blue}), 32'(e1));
      e1 = e0;
      bus.DrawX       = 10'(x);
      bus.DrawY       = 10'(y);
      bus.blank       = bl;
      bus.frame_start = fs;
      bus.lives_in    = 3'(lv);
      e0 = model_pix(x, y, bl);
      #1;
      check("addr", 32'(bus.rom_addr), 32'(model_addr(x, y)));
      if (fs && !reset) model_frame(lv);
   endtask

   task automatic set_reset(input bit v);
      @(negedge vga_clk);
      reset = v;
      if (v) begin
         #1;
         check("rst_out", 32'({bus.pixel_on, bus.red, bus.green, bus.blue}), 32'd0);
         e0 = 13'd0;
         e1 = 13'd0;
         lives_m = 0;
         ghost_m = 0;
         blink_m = 0;
      end
   endtask

   // One frame: frame_start, a probe at texel 0 of every slot, then random pixels.
   task automatic frame(input int lv, input bit jitter_lives, input int npix);
      step(0, 0, 1'b0, 1'b1, lv);
      for (int s = 0; s < 5; s++) step(16 + 44 * s, 16, 1'b1, 1'b0, lv);
      for (int k = 0; k < npix; k++)
         step($urandom_range(0, 259), $urandom_range(8, 63), $urandom_range(0, 7) != 0,
              1'b0, jitter_lives ? int'($urandom_range(0, 7)) : lv);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 3'($urandom_range(0, 7));
      rom[0]  = 3'd5;
      rom[1]  = 3'd0;
      rom[37] = 3'd6;
      bus.DrawX       = '0;
      bus.DrawY       = '0;
      bus.blank       = 1'b0;
      bus.frame_start = 1'b0;
      bus.lives_in    = '0;

      repeat (3) @(negedge vga_clk);
      check("rst_state", 32'({bus.pixel_on, bus.red, bus.green, bus.blue}), 32'd0);
      set_reset(1'b0);

      // Three lives, raster over the icon row region.
      step(0, 0, 1'b0, 1'b1, 3);
      for (int y = 12; y < 60; y++)
         for (int x = 0; x < 250; x++) step(x, y, 1'b1, 1'b0, 3);

      // Latency, blank, transparency, addressing and gap probes.
      step(16, 16, 1'b1, 1'b0, 3);
      step(16, 16, 1'b0, 1'b0, 3);
      step(20, 16, 1'b1, 1'b0, 3);
      step(16 + 4 * 7 + 1, 16 + 4 * 3 + 2, 1'b1, 1'b0, 3);
      step(56, 20, 1'b1, 1'b0, 3);
      step(600, 300, 1'b1, 1'b0, 3);

      // Loss of one life, raise back mid-blink, lose again and let the blink expire.
      for (int f = 0; f < 20; f++) frame(2, 1'b0, 6);
      for (int f = 0; f < 3; f++)  frame(3, 1'b0, 6);
      for (int f = 0; f < 55; f++) frame(2, 1'b0, 6);

      // Count above the slot count, with lives_in jittering between frame pulses.
      for (int f = 0; f < 4; f++) frame(7, 1'b1, 15);
      for (int f = 0; f < 6; f++) frame(int'($urandom_range(0, 7)), 1'b1, 15);

      // Reset in the middle of a frame with four lives drawn.
      frame(4, 1'b0, 4);
      step(16, 16, 1'b1, 1'b0, 4);
      step(60, 16, 1'b1, 1'b0, 4);
      set_reset(1'b1);
      step(16, 16, 1'b1, 1'b0, 4);
      set_reset(1'b0);
      for (int s = 0; s < 5; s++) step(16 + 44 * s, 16, 1'b1, 1'b0, 4);
      frame(4, 1'b0, 10);
      step(600, 300, 1'b0, 1'b0, 4);
      step(600, 300, 1'b0, 1'b0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/life_icon_renderer.md
Name: life_icon_renderer

Overview:
- Parametrised successor to the single-sprite full-screen mapper.
- Draws a row of up to MAX_LIVES scaled life icons at a fixed screen origin, driven by a live-count input.
- The count is latched once per frame. A lost life blinks for a programmable number of frames before it disappears.
- Drives an external synchronous sprite ROM and a combinational palette. Emits registered RGB plus a pixel_on flag, so the downstream mixer can layer icons over the playfield.

Parameters:
- ICON_W, 10, icon width in ROM texels
- ICON_H, 10, icon height in ROM texels
- SCALE_SHIFT, 2, screen pixels per texel = 1<<SCALE_SHIFT (both axes)
- MAX_LIVES, 5, number of icon slots
- SPACING, 4, blank screen pixels between slots
- X0, 16, left edge of slot 0 (DrawX)
- Y0, 16, top edge of the icon row (DrawY)
- IDX_W, 3, palette index width
- ADDR_W, 8, ROM address width; must satisfy ICON_W*ICON_H <= 2^ADDR_W
- BLINK_FRAMES, 48, frames a lost icon blinks
- BLINK_BIT, 2, bit of the blink counter that gates ghost visibility
- CNT_W, 3, width of lives_in; must satisfy 2^CNT_W > MAX_LIVES

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video (same sense as the existing mappers)
- frame_start  in  1  one-cycle pulse, once per frame, before the first visible line
- lives_in  in  CNT_W  requested life count; may change at any time
- rom_addr  out  ADDR_W  texel address to the synchronous ROM (1-cycle read latency)
- rom_q  in  IDX_W  ROM data
- pal_index  out  IDX_W  palette index = rom_q
- pal_red, pal_green, pal_blue  in  4 each  combinational palette outputs
- red, green, blue  out  4 each  registered pixel colour
- pixel_on  out  1  registered; icon pixel is opaque at this position

Behaviour:

Reset:
- red, green, blue, pixel_on = 0.
- lives_q = 0, blink_left = 0, ghost_slot = 0, all pipeline registers = 0.

Geometry (computed combinationally from DrawX/DrawY):
- PW = ICON_W<<SCALE_SHIFT; PH = ICON_H<<SCALE_SHIFT; PITCH = PW+SPACING.
- relX = DrawX-X0; relY = DrawY-Y0.
- in_row: Y0 <= DrawY < Y0+PH and X0 <= DrawX < X0+MAX_LIVES*PITCH.
- slot = relX / PITCH; off = relX - slot*PITCH. Division is by a constant; no assumption of one DrawX step per clock.
- hit = in_row & (off < PW) & (slot < lives_q | (slot == ghost_slot & blink_left != 0 & blink_left[BLINK_BIT])).
- rom_addr = (relY>>SCALE_SHIFT)*ICON_W + (off>>SCALE_SHIFT) when in_row, else 0.

Pipeline, total latency 2 clocks from DrawX/DrawY/blank to outputs:
- Stage 1 (edge t+1): register hit and blank into hit_d and blank_d. The ROM returns rom_q for the cycle-t address.
- Stage 2 (edge t+2): on = hit_d & blank_d & (rom_q != 0). Index 0 is transparent.
  - pixel_on <= on.
  - {red, green, blue} <= on ? palette : 0.

Frame latch, on frame_start only:
- n = min(lives_in, MAX_LIVES).
- n < lives_q: ghost_slot <= n; blink_left <= BLINK_FRAMES.
- n > lives_q: blink_left <= 0 (cancels blink).
- n == lives_q and blink_left != 0: blink_left decrements.
- In every case lives_q <= n.
- A second loss during a blink restarts the blink on the new ghost_slot.
- A lives_in change between pulses has no visible effect until the next frame_start.
- The ghost slot is always >= lives_q, so there is no double-draw.

Reset mid-frame:
- Outputs go to 0 immediately.
- No icons are drawn until the first frame_start after reset deasserts.

Test Plan:
- Reset, lives_in=3, one frame_start, raster frame. Required:
  - pixel_on only for DrawX in [16,56), [60,100), [104,144) with DrawY in [16,56).
  - RGB = 0 elsewhere; slots 3 and 4 dark.
- Single-pixel probe at DrawX=16, DrawY=16, blank=1, rom_q nonzero for address 0. Required:
  - pixel_on and palette RGB appear exactly 2 clocks later.
  - blank=0 at the probe gives 0.
  - rom_q=0 gives pixel_on=0.
- Scaling/addressing check at DrawX=X0+4*7+1, DrawY=Y0+4*3+2. Required: rom_addr = 3*10+7 = 37.
  - Gap pixel at DrawX=56 (off=40): rom_addr sampled, but pixel_on = 0.
- Lives 3 then 2 at the next frame_start. Required:
  - Slot 2 visible on frames where blink_left[2]=1 and hidden otherwise, for 48 frames; then permanently off.
  - Raising back to 3 mid-blink shows slot 2 solid from the next frame.
- lives_in=7 (above MAX_LIVES). Required: exactly 5 slots drawn.
  - lives_in toggled mid-frame without frame_start: no change in drawn slots.
- Assert reset mid-frame with lives=4. Required: outputs 0 within the same clock; icons reappear only after the next frame_start.
